kpg_sum_stage16: RTL and testbench



---
 rtl/kpg_pkg.sv | 29 ++
 rtl/kpg_sum_stage16_if.sv | 25 ++
 rtl/kpg_sum_core.sv | 31 +++
 rtl/kpg_sum_stage16.sv | 91 +++++++++
 tb/tb_kpg_sum_stage16.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/kpg_pkg.sv
// Shared definitions for the KPG final-sum stage: carry codes, legality check
// and the buffered result entry.
package kpg_pkg;

  localparam int unsigned SUM_W = 16;

  localparam logic [1:0] KPG_KILL = 2'b00;
  localparam logic [1:0] KPG_GEN  = 2'b11;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             cout;
    logic             zero;
  } sum_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  localparam sum_entry_t RESET_ENTRY = '{sum: {SUM_W{1'b0}}, cout: 1'b0, zero: 1'b1};

  // A resolved carry is either kill or generate; mixed codes are propagate leftovers.
  function automatic logic kpg_legal(input logic [1:0] code);
    return (code == KPG_KILL) || (code == KPG_GEN);
  endfunction

endpackage

// File: rtl/kpg_sum_stage16_if.sv
// Upstream/downstream handshake bundle of the KPG final-sum stage.
interface kpg_sum_stage16_if #(parameter int unsigned W = 16);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] kpg;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   sum;
  logic           cout;
  logic           zero;

  modport master (
    output in_valid, a, b, kpg, out_ready,
    input  in_ready, out_valid, sum, cout, zero
  );

  modport slave (
    input  in_valid, a, b, kpg, out_ready,
    output in_ready, out_valid, sum, cout, zero
  );

endinterface

// File: rtl/kpg_sum_core.sv
// Combinational carry decode, sum, carry-out, zero detect and illegal-code check.
module kpg_sum_core
  import kpg_pkg::*;
#(
  parameter int unsigned W = SUM_W
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2*W-1:0] kpg,
  output logic [W-1:0]   sum,
  output logic           cout,
  output logic           zero,
  output logic           illegal
);

  logic [W-1:0] carry_s;

  // Upper bit of each code is the carry, even when the code is illegal.
  always_comb begin
    carry_s = {W{1'b0}};
    illegal = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      carry_s[i] = kpg[2*i+1];
      illegal    = illegal | ~kpg_legal(kpg[2*i +: 2]);
    end
    sum  = a ^ b ^ carry_s;
    cout = (a[W-1] & b[W-1]) | ((a[W-1] ^ b[W-1]) & carry_s[W-1]);
    zero = (sum == {W{1'b0}});
  end

endmodule

// File: rtl/kpg_sum_stage16.sv
// Registered final-sum stage of the 16-bit KPG adder with a 2-entry skid buffer
// and a sticky illegal-carry-code flag.
module kpg_sum_stage16
  import kpg_pkg::*;
#(
  parameter int unsigned W = SUM_W
) (
  input  logic               clk,
  input  logic               rst_n,
  kpg_sum_stage16_if.slave   bus,
  input  logic               err_clr,
  output logic               err
);

  buf_state_t state_r;
  sum_entry_t head_r;
  sum_entry_t tail_r;
  sum_entry_t new_s;
  logic       err_r;
  logic       illegal_s;
  logic       in_xfer_s;
  logic       out_xfer_s;

  kpg_sum_core #(.W(W)) u_core (
    .a       (bus.a),
    .b       (bus.b),
    .kpg     (bus.kpg),
    .sum     (new_s.sum),
    .cout    (new_s.cout),
    .zero    (new_s.zero),
    .illegal (illegal_s)
  );

  // in_ready is a pure state decode so it never depends on out_ready.
  assign bus.in_ready  = (state_r != ST_FULL);
  assign bus.out_valid = (state_r != ST_EMPTY);
  assign bus.sum       = head_r.sum;
  assign bus.cout      = head_r.cout;
  assign bus.zero      = head_r.zero;
  assign err           = err_r;

  assign in_xfer_s  = bus.in_valid & bus.in_ready;
  assign out_xfer_s = bus.out_valid & bus.out_ready;

  // Occupancy FSM, head/tail entries and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      head_r  <= RESET_ENTRY;
      tail_r  <= RESET_ENTRY;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            head_r  <= new_s;
            state_r <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_xfer_s, out_xfer_s})
            2'b10: begin
              tail_r  <= new_s;
              state_r <= ST_FULL;
            end
            2'b01: state_r <= ST_EMPTY;
            2'b11: head_r  <= new_s;
            default: state_r <= ST_ONE;
          endcase
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            head_r  <= tail_r;
            state_r <= ST_ONE;
          end
        end
        default: state_r <= ST_EMPTY;
      endcase

      // A new illegal transfer outranks a simultaneous clear.
      if (in_xfer_s && illegal_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

endmodule

// File: tb/tb_kpg_sum_stage16.sv
// Scoreboard bench for kpg_sum_stage16: arithmetic reference model, directed
// carry cases, backpressure, full-rate random traffic, error flag and reset.
module tb_kpg_sum_stage16;
  import kpg_pkg::*;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic err_clr = 1'b0;
  logic err;

  kpg_sum_stage16_if #(.W(16)) bus ();

  kpg_sum_stage16 #(.W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_clr (err_clr),
    .err     (err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [17:0] sb[$];   // {sum, cout, zero}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Carry codes derived from true partial sums of the low bits.
  function automatic logic [31:0] model_kpg(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [31:0] k;
    k = 32'h0;
    k[1:0] = cin ? 2'b11 : 2'b00;
    for (int i = 1; i < 16; i++) begin
      int unsigned mask;
      int unsigned s;
      mask = (32'd1 << i) - 32'd1;
      s = (32'(a) & mask) + (32'(b) & mask) + 32'(cin);
      if (s[i]) k[2*i +: 2] = 2'b11;
    end
    return k;
  endfunction

  function automatic logic [17:0] model_out(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    return {t[15:0], t[16], (t[15:0] == 16'd0)};
  endfunction

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    logic [17:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got sum %h cout %b zero %b with nothing expected",
                 bus.sum, bus.cout, bus.zero);
      end else begin
        e = sb.pop_front();
        if ({bus.sum, bus.cout, bus.zero} !== e) begin
          miscompares++;
          $display("FAIL result: got sum %h cout %b zero %b expected sum %h cout %b zero %b",
                   bus.sum, bus.cout, bus.zero, e[17:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] k,
                      input logic [17:0] exp);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.kpg      = k;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(exp);
        @(posedge clk);
        #1;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout: got in_ready 0 for 200 cycles expected acceptance");
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 200 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic send_rand();
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom_range(0, 1));
    send(a, b, model_kpg(a, b, cin), model_out(a, b, cin));
  endtask

  initial begin
    logic [15:0] ia;
    logic [31:0] ik;
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0;
    bus.b         = 16'h0;
    bus.kpg       = 32'h0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset_sum",       32'(bus.sum),       32'd0);
    chk("reset_cout",      32'(bus.cout),      32'd0);
    chk("reset_zero",      32'(bus.zero),      32'd1);
    chk("reset_err",       32'(err),           32'd0);

    // Directed carry chain and wrap-to-zero.
    bus.out_ready = 1'b1;
    send(16'h00FF, 16'h0001, 32'h0003_FFFC, {16'h0100, 1'b0, 1'b0});
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
    chk("latency_sum",   32'(bus.sum),       32'h0100);
    send(16'hFFFF, 16'h0001, 32'hFFFF_FFFC, {16'h0000, 1'b1, 1'b1});
    idle(2);
    drain();

    // Backpressure: two accepted, third held until the sink opens.
    bus.out_ready = 1'b0;
    send_rand();
    send_rand();
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_sum", 32'(bus.sum), 32'(sb[0][17:2]));
    fork
      send_rand();
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_sum2",  32'(bus.sum), 32'(sb[0][17:2]));
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Full-rate random traffic: every cycle must move one result.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("full_rate_in_ready", 32'(bus.in_ready), 32'd1);
      send_rand();
      chk("no_bubble", 32'(bus.out_valid), 32'd1);
    end
    drain();

    // Illegal code at position 5; low bits of a clear so the true carry there is 0.
    ia = 16'($urandom) & 16'hFFE0;
    chk("err_before", 32'(err), 32'd0);
    ik = model_kpg(ia, 16'h0013, 1'b0);
    ik[11:10] = 2'b01;
    send(ia, 16'h0013, ik, model_out(ia, 16'h0013, 1'b0));
    chk("err_set", 32'(err), 32'd1);
    repeat (3) send_rand();
    chk("err_sticky", 32'(err), 32'd1);
    idle(1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    err_clr = 1'b1;
    send(ia, 16'h0013, ik, model_out(ia, 16'h0013, 1'b0));
    err_clr = 1'b0;
    chk("err_set_wins", 32'(err), 32'd1);
    drain();

    // Reset while full: both entries discarded.
    bus.out_ready = 1'b0;
    send_rand();
    send_rand();
    chk("full_before_reset", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    chk("rst_full_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_full_zero",      32'(bus.zero),      32'd1);
    chk("rst_full_err",       32'(err),           32'd0);
    chk("rst_full_in_ready",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    send_rand();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
